// File: rtl/alu16_seq.sv
// Multi-word ALU: one 16-bit ALU is reused for NUM_WORDS passes, LSW first, with the carry chained between passes.
// Optional feature: define ALU16_SEQ_ZERO_FLAG_EN to add a registered all-zero result flag on port zero.

package alu16_seq_pkg;
    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,  // a + b + cin
        OP_SUB   = 3'd1,  // a + ~b + cin (cin=1 means no borrow)
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_XOR   = 3'd4,
        OP_NOT   = 3'd5,  // ~a
        OP_PASSA = 3'd6,
        OP_PASSB = 3'd7
    } alu_op_e;
endpackage

module alu16
    import alu16_seq_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [2:0]  op_i,
    input  logic        cin_i,
    output logic [15:0] y_o,
    output logic        cout_o,
    output logic        ovf_o
);
    logic [15:0] b_eff;
    logic [16:0] sum;

    assign b_eff = (alu_op_e'(op_i) == OP_SUB) ? ~b_i : b_i;
    assign sum   = {1'b0, a_i} + {1'b0, b_eff} + {16'd0, cin_i};

    // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
    always_comb begin
        y_o    = '0;
        cout_o = 1'b0;
        ovf_o  = 1'b0;
        case (alu_op_e'(op_i))
            OP_ADD, OP_SUB: begin
                y_o    = sum[15:0];
                cout_o = sum[16];
                ovf_o  = (a_i[15] == b_eff[15]) && (sum[15] != a_i[15]);
            end
            OP_AND:   y_o = a_i & b_i;
            OP_OR:    y_o = a_i | b_i;
            OP_XOR:   y_o = a_i ^ b_i;
            OP_NOT:   y_o = ~a_i;
            OP_PASSA: y_o = a_i;
            OP_PASSB: y_o = b_i;
            default:  y_o = '0;
        endcase
    end
endmodule

module alu16_seq #(
    parameter int NUM_WORDS = 2,
    localparam int W = 16 * NUM_WORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         overflow
`ifdef ALU16_SEQ_ZERO_FLAG_EN
    ,
    output logic         zero
`endif
);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     a_q, b_q, result_q;
    logic [2:0]       op_q;
    logic             cin_q, carry_q, cout_q, ovf_q, busy_q, done_q, zero_q;

    logic [15:0]  alu_y;
    logic         alu_cin, alu_cout, alu_ovf;
    logic [W-1:0] result_d;

    assign alu_cin = (idx_q == '0) ? cin_q : carry_q;

    alu16 u_alu16 (
        .a_i    (a_q[int'(idx_q)*16 +: 16]),
        .b_i    (b_q[int'(idx_q)*16 +: 16]),
        .op_i   (op_q),
        .cin_i  (alu_cin),
        .y_o    (alu_y),
        .cout_o (alu_cout),
        .ovf_o  (alu_ovf)
    );

    // Result with the current pass's word merged in; the zero flag is taken from this on the last pass.
    always_comb begin
        result_d = result_q;
        result_d[int'(idx_q)*16 +: 16] = alu_y;
    end

    // NOTE: every register, operand latches included, is reset so an aborted run leaves no stale state behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cin_q    <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        cin_q   <= cin;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    result_q <= result_d;
                    carry_q  <= alu_cout;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= alu_cout;
                        ovf_q   <= alu_ovf;
                        zero_q  <= (result_d == '0);
                        idx_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    // A start seen here is deliberately dropped; IDLE samples it next cycle.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
`ifdef ALU16_SEQ_ZERO_FLAG_EN
    assign zero     = zero_q;
`else
    logic unused_zero;
    assign unused_zero = zero_q;
`endif
endmodule

// File: tb/tb_alu16_seq.sv
// Directed self-checking bench for alu16_seq: vector table on a 2-word instance, hand sequences for
// start-while-busy, mid-run reset and a 4-word instance.
module tb_alu16_seq;
    import alu16_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0, cin = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0, result;
    logic        busy, done, cout, overflow;

    logic        start4 = 1'b0, cin4 = 1'b0;
    logic [2:0]  op4 = 3'd0;
    logic [63:0] a4 = '0, b4 = '0, result4;
    logic        busy4, done4, cout4, overflow4;
`ifdef ALU16_SEQ_ZERO_FLAG_EN
    logic zero, zero4;
`endif

    alu16_seq #(.NUM_WORDS(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
`ifdef ALU16_SEQ_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    alu16_seq #(.NUM_WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .result(result4), .cout(cout4), .overflow(overflow4)
`ifdef ALU16_SEQ_ZERO_FLAG_EN
        , .zero(zero4)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        cin;
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[12];

    task automatic run_vec(input vec_t v, input int k);
        int n;
        @(negedge clk);
        start = 1'b1; a = v.a; b = v.b; op = v.op; cin = v.cin;
        @(negedge clk);
        start = 1'b0;
        a = ~v.a; b = ~v.b; op = ~v.op; cin = ~v.cin;
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("vec%0d latency", k), 64'(n), 64'd3);
        check($sformatf("vec%0d result", k), 64'(result), 64'(v.res));
        check($sformatf("vec%0d cout", k), 64'(cout), 64'(v.cout));
        check($sformatf("vec%0d overflow", k), 64'(overflow), 64'(v.ovf));
`ifdef ALU16_SEQ_ZERO_FLAG_EN
        check($sformatf("vec%0d zero", k), 64'(zero), 64'(v.zero));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ndone;
        //         a             b             op        cin   result        cout  ovf   zero
        vecs[0]  = '{32'h0000FFFF, 32'h00000001, OP_ADD,   1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'h7FFFFFFF, 32'h00000001, OP_ADD,   1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'hFFFFFFFF, 32'h00000001, OP_ADD,   1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{32'h00000005, 32'h00000003, OP_SUB,   1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{32'h00000003, 32'h00000005, OP_SUB,   1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'h80000000, 32'h00000001, OP_SUB,   1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{32'hF0F01234, 32'hFF0000FF, OP_AND,   1'b0, 32'hF0000034, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h00000000, 32'h00000000, OP_OR,    1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{32'hA5A55A5A, 32'hFFFF0000, OP_XOR,   1'b0, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h12345678, 32'h11111111, OP_ADD,   1'b1, 32'h2345678A, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'h80000000, 32'h80000000, OP_ADD,   1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{32'h0000FFFF, 32'h12345678, OP_NOT,   1'b0, 32'hFFFF0000, 1'b0, 1'b0, 1'b0};

        // Reset state
        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset cout", 64'(cout), 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        check("reset result4", result4, 64'd0);
        rst_n = 1'b1;

        // Idle with start low stays idle
        repeat (3) @(negedge clk);
        check("idle busy", 64'(busy), 64'd0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Start re-asserted while busy with changing operands; start held into DONE accepted one cycle later
        @(negedge clk);
        start = 1'b1; a = 32'h0000FFFF; b = 32'h00000001; op = OP_ADD; cin = 1'b0;
        @(negedge clk);
        check("busy c1 busy", 64'(busy), 64'd1);
        check("busy c1 done", 64'(done), 64'd0);
        a = 32'h11111111; b = 32'h22222222; op = OP_SUB;
        @(negedge clk);
        check("busy c2 done", 64'(done), 64'd0);
        a = 32'h33333333; b = 32'h44444444;
        @(negedge clk);
        check("busy c3 done", 64'(done), 64'd1);
        check("busy c3 result", 64'(result), 64'h00010000);
        a = 32'h00000002; b = 32'h00000003; op = OP_ADD;
        @(negedge clk);
        check("busy c4 done", 64'(done), 64'd0);
        check("busy c4 busy", 64'(busy), 64'd0);
        check("busy c4 result held", 64'(result), 64'h00010000);
        @(negedge clk);
        check("busy c5 busy", 64'(busy), 64'd1);
        start = 1'b0;
        @(negedge clk);
        check("busy c6 done", 64'(done), 64'd0);
        @(negedge clk);
        check("busy c7 done", 64'(done), 64'd1);
        check("busy c7 result", 64'(result), 64'h00000005);

        // Reset during the second RUN cycle aborts with no done
        @(negedge clk);
        start = 1'b1; a = 32'h12340001; b = 32'h00010001; op = OP_ADD; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort result", 64'(result), 64'd0);
        check("abort done", 64'(done), 64'd0);
        #2;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("abort no activity", 64'(ndone), 64'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("after abort latency", 64'(n), 64'd3);
        check("after abort result", 64'(result), 64'h12350002);

        // Four-word instance
        @(negedge clk);
        start4 = 1'b1; a4 = 64'h0000FFFFFFFFFFFF; b4 = 64'd1; op4 = OP_ADD; cin4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0;
        n = 1;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("w4 latency", 64'(n), 64'd5);
        check("w4 result", result4, 64'h0001000000000000);
        check("w4 cout", 64'(cout4), 64'd0);
        check("w4 overflow", 64'(overflow4), 64'd0);
`ifdef ALU16_SEQ_ZERO_FLAG_EN
        check("w4 zero", 64'(zero4), 64'd0);
`endif
        @(negedge clk);
        start4 = 1'b1; a4 = 64'hFFFFFFFFFFFFFFFF; b4 = 64'd1;
        @(negedge clk);
        start4 = 1'b0;
        n = 1;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("w4 wrap latency", 64'(n), 64'd5);
        check("w4 wrap result", result4, 64'd0);
        check("w4 wrap cout", 64'(cout4), 64'd1);
`ifdef ALU16_SEQ_ZERO_FLAG_EN
        check("w4 wrap zero", 64'(zero4), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
